// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences 8-bit and chained 16-bit requests through an external
// combinational ALU and maintains the architectural F register (Z N H C).
module alu_sequencer #(
   parameter int unsigned OPCODE_WIDTH = 3,
   parameter int unsigned DATA_WIDTH   = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic [OPCODE_WIDTH-1:0]   i_req_op,
   input  logic                      i_req_wide,
   input  logic [2*DATA_WIDTH-1:0]   i_req_a,
   input  logic [2*DATA_WIDTH-1:0]   i_req_b,
   input  logic [3:0]                i_req_mask,
   output logic [DATA_WIDTH-1:0]     o_alu_a,
   output logic [DATA_WIDTH-1:0]     o_alu_b,
   output logic [OPCODE_WIDTH-1:0]   o_alu_control,
   output logic                      o_alu_cin,
   input  logic [DATA_WIDTH-1:0]     i_alu_data,
   input  logic [DATA_WIDTH-1:0]     i_alu_flags,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic [2*DATA_WIDTH-1:0]   o_res_data,
   output logic [DATA_WIDTH-1:0]     o_flags,
   input  logic                      i_f_we,
   input  logic [DATA_WIDTH-1:0]     i_f_data
);

   localparam int unsigned WIDE_WIDTH = 2 * DATA_WIDTH;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADC = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_SBC = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_CP  = OPCODE_WIDTH'(7);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                    state_q;
   logic [OPCODE_WIDTH-1:0]   op_q;
   logic                      wide_q;
   logic [DATA_WIDTH-1:0]     a_hi_q;
   logic [DATA_WIDTH-1:0]     b_hi_q;
   logic [3:0]                mask_q;
   logic [3:0]                f_q;       // {Z,N,H,C}
   logic                      lo_z_q;
   logic [WIDE_WIDTH-1:0]     res_q;
   logic                      res_valid_q;
   logic                      req_ready_q;
   logic [DATA_WIDTH-1:0]     alu_a_q;
   logic [DATA_WIDTH-1:0]     alu_b_q;
   logic [OPCODE_WIDTH-1:0]   alu_ctrl_q;
   logic                      alu_cin_q;

   logic [3:0]                f_load_d;
   logic [3:0]                new_flags_d;
   logic [3:0]                f_d;
   logic [OPCODE_WIDTH-1:0]   hi_ctrl_d;
   logic                      req_carry_op_d;

   // Low nibble of the flag inputs carries no architectural state.
   logic unused_bits;
   assign unused_bits = ^{i_alu_flags[3:0], i_f_data[3:0]};

   // Next-value helpers: F after external load, masked F update, high-half control.
   always_comb begin
      f_load_d       = i_f_we ? i_f_data[7:4] : f_q;
      req_carry_op_d = (i_req_op == OP_ADC) || (i_req_op == OP_SBC);
      new_flags_d    = wide_q ? {lo_z_q & i_alu_flags[7], i_alu_flags[6:4]}
                              : i_alu_flags[7:4];
      f_d            = (f_q & ~mask_q) | (new_flags_d & mask_q);
      case (op_q)
         OP_ADD, OP_ADC:        hi_ctrl_d = OP_ADC;
         OP_SUB, OP_SBC, OP_CP: hi_ctrl_d = OP_SBC;
         default:               hi_ctrl_d = op_q;
      endcase
   end

   // Sequencer FSM with registered ALU-side and result-side outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         wide_q      <= 1'b0;
         a_hi_q      <= '0;
         b_hi_q      <= '0;
         mask_q      <= '0;
         f_q         <= '0;
         lo_z_q      <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= '0;
         alu_cin_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_f_we) begin
                  f_q <= i_f_data[7:4];
               end
               if (i_req_valid) begin
                  op_q        <= i_req_op;
                  wide_q      <= i_req_wide;
                  a_hi_q      <= i_req_a[WIDE_WIDTH-1:DATA_WIDTH];
                  b_hi_q      <= i_req_b[WIDE_WIDTH-1:DATA_WIDTH];
                  mask_q      <= i_req_mask;
                  alu_a_q     <= i_req_a[DATA_WIDTH-1:0];
                  alu_b_q     <= i_req_b[DATA_WIDTH-1:0];
                  alu_ctrl_q  <= i_req_op;
                  // A same-cycle F load is visible to the carry-in of the low pass.
                  alu_cin_q   <= req_carry_op_d & f_load_d[0];
                  req_ready_q <= 1'b0;
                  state_q     <= S_LO;
               end
            end
            S_LO: begin
               res_q  <= WIDE_WIDTH'(i_alu_data);
               lo_z_q <= i_alu_flags[7];
               if (wide_q) begin
                  alu_a_q    <= a_hi_q;
                  alu_b_q    <= b_hi_q;
                  alu_ctrl_q <= hi_ctrl_d;
                  alu_cin_q  <= i_alu_flags[4];
                  state_q    <= S_HI;
               end else begin
                  f_q         <= f_d;
                  alu_a_q     <= '0;
                  alu_b_q     <= '0;
                  alu_ctrl_q  <= '0;
                  alu_cin_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_HI: begin
               res_q[WIDE_WIDTH-1:DATA_WIDTH] <= i_alu_data;
               f_q         <= f_d;
               alu_a_q     <= '0;
               alu_b_q     <= '0;
               alu_ctrl_q  <= '0;
               alu_cin_q   <= 1'b0;
               res_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (i_res_ready) begin
                  res_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req_ready   = req_ready_q;
   assign o_alu_a       = alu_a_q;
   assign o_alu_b       = alu_b_q;
   assign o_alu_control = alu_ctrl_q;
   assign o_alu_cin     = alu_cin_q;
   assign o_res_valid   = res_valid_q;
   assign o_res_data    = res_q;
   assign o_flags       = DATA_WIDTH'({f_q, 4'b0000});

endmodule
